// File: rtl/puf_apb_m04_master_pkg.sv
// Purpose: shared widths, timeout default and FSM encoding for the slave-04 APB master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DEF_* width/timeout defaults, apb_state_e FSM encoding, alignment helper.
package puf_apb_m04_master_pkg;

    localparam int DEF_APB_ADDR_WIDTH   = 32;
    localparam int DEF_APB_DATA_WIDTH   = 32;
    localparam int DEF_APB_STROBE_WIDTH = DEF_APB_DATA_WIDTH / 8;
    localparam int DEF_TIMEOUT_CYCLES   = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Word-aligned accesses only; the PUF wrapper has no byte lanes addressing.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/puf_apb_m04_master_apb_wait_timer.sv
// Purpose: saturating wait-state counter with clear/enable and an expired flag.
// Latency: expired is combinational from the count; count updates one cycle after en.
// Backpressure: none; stops counting once the limit is reached (never wraps).
// Ports: clk/rst_n clock and async active-low reset; clr zeroes the count (wins over en);
//        en advances the count; expired is high while count == LIMIT-1.
module apb_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Compare with >= so a stray extra enable can never push past the limit.
    assign expired = (cnt >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/puf_apb_m04_master.sv
// Purpose: single-outstanding APB4 master bridging a valid/ready request to slave port 04.
// Latency: accept N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3 (+1 per wait state).
// Backpressure: req_ready only in IDLE; response held until rsp_ready; stalled slaves time out.
// Ports: pclk/presetn clock and async active-low reset; req_* request channel;
//        rsp_* response channel (rdata, err, timeout); p* APB master bus toward slave 04.
module puf_apb_m04_master
    import puf_apb_m04_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH   = DEF_APB_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH   = DEF_APB_DATA_WIDTH,
    parameter int APB_STROBE_WIDTH = DEF_APB_STROBE_WIDTH,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                        pclk,
    input  logic                        presetn,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [APB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [APB_DATA_WIDTH-1:0]   req_wdata,
    input  logic [APB_STROBE_WIDTH-1:0] req_strb,
    input  logic [2:0]                  req_prot,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [APB_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,

    output logic [APB_ADDR_WIDTH-1:0]   paddr,
    output logic [APB_DATA_WIDTH-1:0]   pwdata,
    output logic [2:0]                  pprot,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [APB_STROBE_WIDTH-1:0] pstrb,

    input  logic                        pready,
    input  logic                        pslverr,
    input  logic [APB_DATA_WIDTH-1:0]   prdata
);

    apb_state_e state;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;

    assign req_ready = (state == IDLE);

    // Clearing during SETUP makes the first ACCESS cycle start at count 0.
    assign timer_clr = (state == SETUP);
    assign timer_en  = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (pclk),
        .rst_n   (presetn),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // The APB output registers double as the registered request: they are
    // loaded on accept and zeroed when the transfer leaves ACCESS, so the bus
    // reads all-zero outside SETUP/ACCESS without extra muxing.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            pwrite      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_addr[1:0])) begin
                            // Rejected locally; the slave never sees it.
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state       <= RESP;
                        end else begin
                            psel   <= 1'b1;
                            paddr  <= req_addr;
                            pwrite <= req_write;
                            pprot  <= req_prot;
                            pwdata <= req_write ? req_wdata : '0;
                            pstrb  <= req_write ? req_strb  : '0;
                            state  <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready || timer_expired) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= '0;
                        pstrb     <= '0;
                        pprot     <= '0;
                        pwrite    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        // pready is tested first so a completion on the last
                        // allowed cycle is reported normally, not as a timeout.
                        if (pready) begin
                            rsp_err     <= pslverr;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= pwrite ? '0 : prdata;
                        end else begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= '0;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_apb_m04_master.sv
// Purpose: self-checking bench for puf_apb_m04_master (TIMEOUT_CYCLES=4).
// Latency: response latency measured in cycles from the accept edge.
// Backpressure: exercises rsp_ready hold-off and back-to-back requests.
module tb_puf_apb_m04_master;

    localparam int TMO = 4;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic [31:0] prdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    puf_apb_m04_master #(
        .APB_ADDR_WIDTH   (32),
        .APB_DATA_WIDTH   (32),
        .APB_STROBE_WIDTH (4),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pstrb       (pstrb),
        .pready      (pready),
        .pslverr     (pslverr),
        .prdata      (prdata)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;     // index of the ACCESS cycle that sees pready
        logic        slverr;
        logic [31:0] prdata;
        int          hold;      // cycles rsp_ready is held low in RESP
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;   // cycles from accept edge to rsp_valid
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT in IDLE; leaves at a negedge in IDLE.
    task automatic run_vec(input vec_t v);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        int          c;
        bit          got;
        int          psel_cnt;
        bit          bus_bad;
        bit          hold_bad;
        logic [31:0] snap_rdata;
        logic        snap_err;
        logic        snap_to;

        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.to    = v.exp_to;
        e.lat   = v.exp_lat;
        sb.push_back(e);

        exp_pwdata = v.write ? v.wdata : 32'h0;
        exp_pstrb  = v.write ? v.strb  : 4'h0;

        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        req_prot  = v.prot;
        prdata    = v.prdata;
        pslverr   = v.slverr;
        chk("req_ready_idle", req_ready, 1'b1);
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;

        c = 1; got = 0; psel_cnt = 0; bus_bad = 0;
        while (!got && c <= 40) begin
            pready = 1'b0;
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (psel) begin
                    psel_cnt++;
                    if ({paddr, pwrite, pwdata, pstrb, pprot, penable} !==
                        {v.addr, v.write, exp_pwdata, exp_pstrb, v.prot, (c >= 2)})
                        bus_bad = 1;
                end else if (penable) begin
                    bus_bad = 1;
                end
                if (c == 2 + v.waits) pready = 1'b1;
                @(negedge pclk);
                c++;
            end
        end

        if (!got) begin
            chk("rsp_valid_wait", 1'b0, 1'b1);
            void'(sb.pop_front());
            return;
        end

        got_e = sb.pop_front();
        chk("rsp_payload", {rsp_rdata, rsp_err, rsp_timeout}, {got_e.rdata, got_e.err, got_e.to});
        chk("rsp_latency", c, got_e.lat);
        chk("psel_cycles", psel_cnt, (v.addr[1:0] != 2'b00) ? 0 : got_e.lat - 1);
        chk("bus_fields", bus_bad, 1'b0);
        chk("resp_bus_idle",
            {psel, penable, paddr, pwdata, pstrb, pwrite, pprot, req_ready}, 75'h0);

        snap_rdata = rsp_rdata;
        snap_err   = rsp_err;
        snap_to    = rsp_timeout;
        hold_bad   = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge pclk);
            if (!rsp_valid || rsp_rdata !== snap_rdata || rsp_err !== snap_err ||
                rsp_timeout !== snap_to || req_ready || psel || penable)
                hold_bad = 1;
        end
        if (v.hold > 0) chk("resp_hold_stable", hold_bad, 1'b0);

        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        pslverr   = 1'b0;
        chk("back_to_idle", {req_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rv_bad;

        //              wr    addr          wdata         strb  prot  waits slv  prdata        hold exp_rdata     err   to    lat
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 3'd0, 0,  1'b0, 32'h0,         0, 32'h0,         1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h1111_1111, 4'hF, 3'd2, 3,  1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 3'd0, 1,  1'b1, 32'h1234_5678, 1, 32'h1234_5678, 1'b1, 1'b0, 4};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 3'd1, 99, 1'b0, 32'hCAFE_F00D, 0, 32'h0,         1'b1, 1'b1, 6};
        vecs[4] = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 3'd0, 3,  1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 4'hF, 3'd0, 0,  1'b0, 32'h0,         5, 32'h0,         1'b1, 1'b0, 1};
        vecs[6] = '{1'b1, 32'h0000_0040, 32'h8765_4321, 4'h3, 3'd5, 2,  1'b1, 32'h0,         0, 32'h0,         1'b1, 1'b0, 5};
        vecs[7] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 3'd0, 0,  1'b0, 32'h55AA_55AA, 2, 32'h55AA_55AA, 1'b0, 1'b0, 3};
        vecs[8] = '{1'b1, 32'h0000_0048, 32'h0000_0001, 4'h1, 3'd0, 5,  1'b0, 32'h0,         0, 32'h0,         1'b1, 1'b1, 6};
        vecs[9] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 3'd0, 0,  1'b0, 32'h7777_7777, 0, 32'h0,         1'b1, 1'b0, 1};

        // Reset state.
        repeat (3) @(negedge pclk);
        chk("reset_apb_outputs", {psel, penable, paddr, pwdata, pstrb, pwrite, pprot}, 74'h0);
        chk("reset_rsp_outputs", {req_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {1'b1, 35'h0});
        presetn = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset pulsed while the slave is stalling in ACCESS.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0050;
        req_strb  = 4'h0;
        req_prot  = 3'd0;
        pready    = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        @(negedge pclk);
        chk("midreset_in_access", {psel, penable}, 2'b11);
        #1 presetn = 1'b0;
        #1 chk("midreset_async_drop", {psel, penable}, 2'b00);
        rv_bad = 0;
        repeat (2) begin
            @(negedge pclk);
            if (rsp_valid || psel || penable) rv_bad = 1;
        end
        presetn = 1'b1;
        @(negedge pclk);
        if (rsp_valid) rv_bad = 1;
        chk("midreset_no_rsp", rv_bad, 1'b0);
        chk("midreset_req_ready", req_ready, 1'b1);

        // Normal traffic resumes after the aborted transfer.
        run_vec(vecs[1]);
        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_apb_m04_master.md
# puf_apb_m04_master

Single-outstanding APB4 master that turns a simple valid/ready request from the SAP authentication controller into APB SETUP/ACCESS transfers toward slave port 04 (PUF wrapper), and returns read data and error status on a valid/ready response channel. It sits directly upstream of the PUF slave wrapper and drives its `psel_04`/`penable_04`/`paddr_04` bus. It also bounds stalled slaves with a wait-state timeout.

## Interface
- `APB_ADDR_WIDTH`, 32, APB address width (from `config_pkg.vh`)
- `APB_DATA_WIDTH`, 32, APB data width
- `APB_STROBE_WIDTH`, 4, write strobe width (`APB_DATA_WIDTH/8`)
- `TIMEOUT_CYCLES`, 256, maximum ACCESS cycles without `pready` before abort (≥1)
- `pclk` in 1: single clock; all logic rising-edge.
- `presetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_write` in 1, `req_addr` in APB_ADDR_WIDTH, `req_wdata` in APB_DATA_WIDTH, `req_strb` in APB_STROBE_WIDTH, `req_prot` in 3: request payload.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out APB_DATA_WIDTH, `rsp_err` out 1, `rsp_timeout` out 1: response payload.
- `paddr` out APB_ADDR_WIDTH, `pwdata` out APB_DATA_WIDTH, `pprot` out 3, `psel` out 1, `penable` out 1, `pwrite` out 1, `pstrb` out APB_STROBE_WIDTH: APB master outputs.
- `pready` in 1, `pslverr` in 1, `prdata` in APB_DATA_WIDTH: APB slave returns.

## Operation
- FSM: IDLE → SETUP → ACCESS → RESP → IDLE; reset state IDLE.
- IDLE:
  - `req_ready`=1 (combinational, state==IDLE).
  - On `req_valid&&req_ready`, register all payload fields.
  - If `req_addr[1:0]!=0` (misaligned), go directly to RESP with `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0; no APB transfer.
  - Otherwise go to SETUP.
- SETUP: `psel`=1, `penable`=0. Go to ACCESS unconditionally.
- ACCESS:
  - `psel`=1, `penable`=1.
  - On `pready`=1: capture `pslverr` into `rsp_err`, and `prdata` into `rsp_rdata` for reads (0 for writes). Go to RESP.
  - Each ACCESS cycle without `pready` increments the wait counter.
  - When the counter equals TIMEOUT_CYCLES−1 and `pready`=0: abort to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - If `pready` and the timeout limit coincide, `pready` wins (normal completion).
- RESP:
  - `psel`=`penable`=0, `rsp_valid`=1, payload stable.
  - Hold until `rsp_ready`, then go to IDLE.
- APB rules:
  - `paddr`, `pwrite`, `pprot`, `pwdata`, `pstrb` come from the registered request and are stable from SETUP through the end of ACCESS.
  - For reads, `pwdata`=0 and `pstrb`=0.
  - Outside SETUP/ACCESS, all APB outputs are 0.
- Wait counter:
  - Width `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to SETUP; never wraps (saturating compare).
- Reset mid-transfer: `presetn` low in any state forces IDLE immediately; the pending response is discarded and `psel`/`penable` drop asynchronously.

## Timing
- Reset values: all APB outputs 0, `rsp_valid`/`rsp_err`/`rsp_timeout` 0, `rsp_rdata` 0, state IDLE (`req_ready` reads 1).
- Accept at edge N. SETUP is cycle N+1 and ACCESS is cycle N+2.
- With zero wait states, `rsp_valid` asserts at N+3.
- Each wait state adds one cycle.
- Misaligned request: `rsp_valid` at N+1.
- Back-to-back: if `rsp_ready`=1 in the first RESP cycle, the next request is accepted one cycle later (IDLE). Throughput is 1 transfer per 4 cycles minimum.
- Timeout: `rsp_valid` asserts TIMEOUT_CYCLES+2 cycles after accept.
- Only one transaction is outstanding; no request buffering.

## Structure
- `config_pkg.vh` holds the APB widths, the `TIMEOUT_CYCLES` default, and the FSM state localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3).
- One natural sub-module: `apb_wait_timer`. It provides the clear/enable saturating counter with an `expired` output, and is reusable by other SAP master ports.
- A top-level pairing with the slave-04 wrapper is done in the SAP integration top, not here.

## Test plan
- Zero-wait write, addr 0x0000_0010, wdata 0xA5A5_1234, strb 0xF → `psel` at N+1, `penable` at N+2, `pwrite`=1, `rsp_valid` at N+3 with `rsp_err`=0.
- Read with 3 wait states, `prdata`=0xDEAD_BEEF → `rsp_valid` at N+6, `rsp_rdata`=0xDEAD_BEEF; `pstrb`=0 and `pwdata`=0 throughout.
- Slave returns `pslverr`=1 on read → `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=`prdata`.
- TIMEOUT_CYCLES=4, `pready` held low → abort after 4 ACCESS cycles: `rsp_err`=1, `rsp_timeout`=1, bus idle. A second run asserting `pready` exactly on the 4th ACCESS cycle completes normally.
- Misaligned addr 0x0000_0006 → no `psel`, `rsp_valid` at N+1, `rsp_err`=1. Holding `rsp_ready`=0 for 5 cycles keeps the payload stable and `req_ready`=0.
- `presetn` pulsed low during ACCESS → `psel`/`penable` drop immediately, no `rsp_valid`, and `req_ready`=1 after release.
